mips_fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the fetch PC and issues sequential word fetches to instruction memory over a valid/ready request channel, with in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents the head to the decoder as inst/inst_pc/inst_valid.
- Handles decode back-pressure (id_stall) and control-flow redirects (branch, jump, exception, ERET), discarding stale in-flight responses.

---
 rtl/mips_fetch_queue.sv | 115 +++++++++++
 tb/tb_mips_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word fetches and queues
// returned instructions for decode. Optional same-cycle response bypass: FETCH_BYPASS_EN.
module mips_fetch_queue #(
  parameter int                  DEPTH    = 4,
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [31:0]         imem_resp_data,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                id_stall,
  output logic [31:0]         inst,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic [PC_WIDTH-1:0] inst_pc4,
  output logic                inst_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Stale responses can pile up across several redirects, so give the drop counter headroom.
  localparam int DW = CW + 3;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] fetch_pc_reg;
  logic [PC_WIDTH-1:0] resp_pc_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       outstanding_reg;
  logic [DW-1:0]       discard_reg;
  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [31:0]         inst_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];

  logic [CW:0]         occupancy;
  logic                req_fire;
  logic                resp_stale;
  logic                resp_live;
  logic                q_empty;
  logic                q_pop;
  logic                q_write;
  logic [31:0]         head_inst;
  logic [PC_WIDTH-1:0] head_pc;

  // outstanding_reg counts only live fetches; stale ones move into discard_reg on redirect.
  assign occupancy      = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign imem_req_valid = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_stale     = imem_resp_valid && (discard_reg != '0);
  assign resp_live      = imem_resp_valid && (discard_reg == '0) && !redirect;
  assign q_empty        = (count_reg == '0);
  assign q_pop          = !q_empty && !id_stall && !redirect;
  assign head_inst      = inst_mem[rd_ptr_reg];
  assign head_pc        = pc_mem[rd_ptr_reg];

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = q_empty && resp_live;
  // A bypassed word the decoder takes right away never touches storage.
  assign q_write    = resp_live && !(bypass_hit && !id_stall);
  assign inst_valid = !q_empty || bypass_hit;
  assign inst       = bypass_hit ? imem_resp_data : (q_empty ? 32'h0 : head_inst);
  assign inst_pc    = bypass_hit ? resp_pc_reg : (q_empty ? '0 : head_pc);
`else
  assign q_write    = resp_live;
  assign inst_valid = !q_empty;
  assign inst       = q_empty ? 32'h0 : head_inst;
  assign inst_pc    = q_empty ? '0 : head_pc;
`endif
  assign inst_pc4   = inst_pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (!reset && q_write) begin
      inst_mem[wr_ptr_reg] <= imem_resp_data;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (redirect) begin
      fetch_pc_reg    <= redirect_pc;
      resp_pc_reg     <= redirect_pc;
      count_reg       <= '0;
      outstanding_reg <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      // Every fetch still in flight becomes stale; a response landing now is dropped here.
      discard_reg     <= discard_reg + DW'(outstanding_reg) + DW'(req_fire)
                         - DW'(imem_resp_valid);
    end else begin
      if (req_fire)   fetch_pc_reg <= fetch_pc_reg + PC_STEP;
      if (resp_live)  resp_pc_reg  <= resp_pc_reg + PC_STEP;
      if (resp_stale) discard_reg  <= discard_reg - DW'(1);
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(resp_live);
      count_reg       <= count_reg + CW'(q_write) - CW'(q_pop);
      if (q_write) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (q_pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: memory model returning the address as data, a scoreboard
// of expected PCs, a startup vector table and directed stall/redirect/bypass sequences.
module tb_mips_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [63:0] inst_pc4;
  logic        inst_valid;

  always #5 clk = ~clk;

  mips_fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4), .inst_valid(inst_valid)
  );

  typedef struct {
    logic        rst;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic [63:0] exp_ipc;
  } vec_t;
  vec_t vecs[8];

  logic [63:0] memq[$];
  logic [63:0] expq[$];
  logic [63:0] nxt_pc = '0;
  logic [63:0] prev_addr = '0;
  logic        prev_wait = 1'b0;
  int          passed = 0;
  int          total = 0;

  logic        r_reset = 1'b1;
  logic        r_stall = 1'b0;
  logic        r_redir = 1'b0;
  logic [63:0] r_rpc = '0;
  int          rdy_mode = 1;  // 0 low, 1 high, 2 random
  int          mem_mode = 1;  // 0 hold, 1 respond every cycle, 2 random

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Drive one cycle's inputs at the falling edge, then check outputs 1 time unit later.
  task automatic cyc_begin();
    logic [63:0] a;
    @(negedge clk);
    reset       = r_reset;
    id_stall    = r_stall;
    redirect    = r_redir;
    redirect_pc = r_rpc;
    imem_req_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    if (!r_reset && memq.size() > 0 &&
        (mem_mode == 1 || (mem_mode == 2 && $urandom_range(0, 1) == 1))) begin
      a = memq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = a[31:0];
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom();
    end
    #1;
    if (r_reset) begin
      check("req_valid_in_reset", 64'(imem_req_valid), 64'(0));
    end else begin
      if (r_redir) begin
        check("req_valid_in_redirect", 64'(imem_req_valid), 64'(0));
      end else begin
        check("req_valid", 64'(imem_req_valid), 64'(expq.size() < DEPTH));
        if (imem_req_valid) check("req_addr", imem_req_addr, nxt_pc);
        if (prev_wait) check("addr_hold", imem_req_addr, prev_addr);
      end
      if (inst_valid) begin
        check("inst_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          a = expq[0];
          check("inst_pc", inst_pc, a);
          check("inst_word", 64'(inst), 64'(a[31:0]));
          check("inst_pc4", inst_pc4, a + 64'd4);
        end
      end else begin
        check("empty_inst", 64'(inst), 64'(0));
        check("empty_pc", inst_pc, 64'(0));
        check("empty_pc4", inst_pc4, 64'd4);
      end
    end
  endtask

  // Update the bench model with what happened this cycle, then let the clock edge pass.
  task automatic cyc_end();
    logic [63:0] a;
    if (r_reset) begin
      memq.delete();
      expq.delete();
      nxt_pc    = '0;
      prev_wait = 1'b0;
    end else begin
      if (inst_valid && !id_stall && !r_redir && expq.size() > 0) begin
        a = expq.pop_front();
        $display("pop pc=%h inst=%h", inst_pc, inst);
      end
      if (r_redir) begin
        expq.delete();
        nxt_pc = r_rpc;
      end
      if (imem_req_valid && imem_req_ready) begin
        memq.push_back(imem_req_addr);
        expq.push_back(nxt_pc);
        nxt_pc = nxt_pc + 64'd4;
      end
      prev_wait = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
    end
    @(posedge clk);
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  initial begin
    int  found;
    vecs[0] = '{rst: 1'b1, exp_rv: 1'b0, exp_addr: 64'd0, exp_iv: 1'b0, exp_ipc: 64'd0};
    for (int c = 1; c < 8; c++) begin
      vecs[c].rst      = 1'b0;
      vecs[c].exp_rv   = 1'b1;
      vecs[c].exp_addr = 64'(4 * (c - 1));
      vecs[c].exp_iv   = (c >= 3 - BYP);
      vecs[c].exp_ipc  = vecs[c].exp_iv ? 64'(4 * (c - 3 + BYP)) : 64'd0;
    end

    // Startup: reset, then free-running fetch with a 1-cycle memory.
    r_reset = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      r_reset = vecs[i].rst;
      cyc_begin();
      check("tbl_req_valid", 64'(imem_req_valid), 64'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) check("tbl_req_addr", imem_req_addr, vecs[i].exp_addr);
      check("tbl_inst_valid", 64'(inst_valid), 64'(vecs[i].exp_iv));
      check("tbl_inst_pc", inst_pc, vecs[i].exp_ipc);
      check("tbl_inst_pc4", inst_pc4, vecs[i].exp_ipc + 64'd4);
      cyc_end();
    end

    // Decode stalled from reset: fetch must stop at DEPTH and the head must hold pc 0.
    r_reset = 1'b1;
    step();
    r_reset = 1'b0;
    r_stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc_begin();
      if (i >= 4) begin
        check("stall_head_valid", 64'(inst_valid), 64'(1));
        check("stall_head_pc", inst_pc, 64'd0);
      end
      if (i == 11) check("stall_req_blocked", 64'(imem_req_valid), 64'(0));
      cyc_end();
    end
    r_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      check("release_valid", 64'(inst_valid), 64'(1));
      check("release_pc", inst_pc, 64'(4 * i));
      cyc_end();
    end
    for (int i = 0; i < 10; i++) step();

    // Memory holds responses, then redirect while one of them lands.
    mem_mode = 0;
    for (int i = 0; i < 4; i++) step();
    mem_mode = 1;
    r_redir  = 1'b1;
    r_rpc    = 64'h1000;
    cyc_begin();
    check("redir_resp_arrives", 64'(imem_resp_valid), 64'(1));
    cyc_end();
    r_redir = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc_begin();
      if (inst_valid) begin
        found = 1;
        check("first_after_redirect", inst_pc, 64'h1000);
      end
      cyc_end();
    end
    check("redirect_timeout", 64'(found), 64'(1));
    for (int i = 0; i < 6; i++) step();

    // Redirect together with a stall into a full queue.
    r_stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    r_redir = 1'b1;
    r_rpc   = 64'h2000;
    cyc_begin();
    check("full_before_redirect", 64'(inst_valid), 64'(1));
    cyc_end();
    r_redir = 1'b0;
    cyc_begin();
    check("redir_flush_valid", 64'(inst_valid), 64'(0));
    check("redir_req_valid", 64'(imem_req_valid), 64'(1));
    check("redir_req_addr", imem_req_addr, 64'h2000);
    cyc_end();
    r_stall = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Random ready, latency, stalls and redirects; the scoreboard checks every cycle.
    rdy_mode = 2;
    mem_mode = 2;
    for (int i = 0; i < 400; i++) begin
      r_stall = ($urandom_range(0, 3) == 0);
      r_redir = ($urandom_range(0, 24) == 0);
      r_rpc   = {32'($urandom()), 32'($urandom())} & ~64'd3;
      step();
    end
    rdy_mode = 1;
    r_stall  = 1'b0;
    r_redir  = 1'b0;
    mem_mode = 1;
    for (int i = 0; i < 20; i++) step();

    // Response latency into an empty queue at pc 0x20.
    r_reset = 1'b1;
    step();
    r_reset  = 1'b0;
    mem_mode = 0;
    r_redir  = 1'b1;
    r_rpc    = 64'h20;
    step();
    r_redir = 1'b0;
    step();
    mem_mode = 1;
    cyc_begin();
    check("bypass_cycle_n_valid", 64'(inst_valid), 64'(BYP));
    cyc_end();
    cyc_begin();
    check("cycle_n1_valid", 64'(inst_valid), 64'(1));
    check("cycle_n1_pc", inst_pc, (BYP != 0) ? 64'h24 : 64'h20);
    cyc_end();
    for (int i = 0; i < 5; i++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
